// File: rtl/ixc_gfifo_port_arb.sv
// Round-robin arbiter with packet lock and credit gating in front of one GFIFO port-gate channel.
// One beat per cycle is forwarded through a registered output stage while downstream credit remains.
module ixc_gfifo_port_arb #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int CREDITS = 8,
    parameter int CW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    gnt,
    output logic               si_vld,
    output logic [DW-1:0]      si_data,
    output logic [2:0]         si_src,
    output logic               si_last,
    input  logic               co_cred,
    output logic [CW-1:0]      cred_cnt,
    output logic               err_ovf,
    output logic               dbg_state,
    output logic [2:0]         dbg_rr_ptr
);

    // Handshake: beat i transfers in any cycle where req[i] && gnt[i]; gnt is
    // combinational, never asserted without credit, and payload is sampled only then.

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   w_sel;
    logic [PW-1:0]   w_rr_next;
    logic [PW:0]     w_pos;
    logic            w_found;
    logic            w_consume;
    logic            w_sel_last;
    logic            w_cred_ok;
    logic [NREQ-1:0] w_gnt;
    logic [CW-1:0]   r_cred_cnt;
    logic            r_err_ovf;
    logic            r_si_vld;
    logic [DW-1:0]   r_si_data;
    logic [2:0]      r_si_src;
    logic            r_si_last;

    assign w_cred_ok = (r_cred_cnt != '0);

    always_comb begin
        w_gnt        = '0;
        w_sel        = r_owner;
        w_found      = 1'b0;
        w_pos        = '0;
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // Cyclic search starting at the round-robin pointer.
                if (w_cred_ok) begin
                    for (int k = 0; k < NREQ; k++) begin
                        w_pos = {1'b0, r_rr_ptr} + (PW+1)'(k);
                        if (w_pos >= (PW+1)'(NREQ)) begin
                            w_pos = w_pos - (PW+1)'(NREQ);
                        end
                        if (!w_found && req[w_pos[PW-1:0]]) begin
                            w_found = 1'b1;
                            w_sel   = w_pos[PW-1:0];
                        end
                    end
                end
                if (w_found) begin
                    w_gnt[w_sel] = 1'b1;
                end
            end
            ST_LOCK: begin
                if (req[r_owner] && w_cred_ok) begin
                    w_gnt[r_owner] = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        w_consume  = |w_gnt;
        w_sel_last = req_last[w_sel];
        if (w_consume) begin
            if (r_state == ST_IDLE && !w_sel_last) begin
                w_next_state = ST_LOCK;
            end else if (r_state == ST_LOCK && w_sel_last) begin
                w_next_state = ST_IDLE;
            end
        end
        w_rr_next = (w_sel == PW'(NREQ-1)) ? '0 : w_sel + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_cred_cnt <= CRED_MAX;
            r_err_ovf  <= 1'b0;
            r_si_vld   <= 1'b0;
            r_si_data  <= '0;
            r_si_src   <= '0;
            r_si_last  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_consume && r_state == ST_IDLE) begin
                r_owner <= w_sel;
            end
            if (w_consume && w_sel_last) begin
                r_rr_ptr <= w_rr_next;
            end
            // A return that lands on a full counter is dropped and flagged.
            if (w_consume && !co_cred) begin
                r_cred_cnt <= r_cred_cnt - 1'b1;
            end else if (co_cred && !w_consume) begin
                if (r_cred_cnt == CRED_MAX) begin
                    r_err_ovf <= 1'b1;
                end else begin
                    r_cred_cnt <= r_cred_cnt + 1'b1;
                end
            end
            r_si_vld <= w_consume;
            if (w_consume) begin
                r_si_data <= req_data[w_sel*DW +: DW];
                r_si_src  <= 3'(w_sel);
                r_si_last <= w_sel_last;
            end
        end
    end

    assign gnt        = w_gnt;
    assign si_vld     = r_si_vld;
    assign si_data    = r_si_data;
    assign si_src     = r_si_src;
    assign si_last    = r_si_last;
    assign cred_cnt   = r_cred_cnt;
    assign err_ovf    = r_err_ovf;
    assign dbg_state  = (r_state == ST_LOCK);
    assign dbg_rr_ptr = 3'(r_rr_ptr);

endmodule

// File: tb/tb_ixc_gfifo_port_arb.sv
// Directed bench for ixc_gfifo_port_arb: round robin, packet lock, credit exhaustion,
// simultaneous consume/return, overflow and reset mid-lock, with a beat scoreboard.
module tb_ixc_gfifo_port_arb;

    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int CREDITS = 8;
    localparam int CW      = 8;
    localparam int W       = 3 + 1 + DW;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    gnt;
    logic               si_vld;
    logic [DW-1:0]      si_data;
    logic [2:0]         si_src;
    logic               si_last;
    logic               co_cred;
    logic [CW-1:0]      cred_cnt;
    logic               err_ovf;
    logic               dbg_state;
    logic [2:0]         dbg_rr_ptr;

    int n_checks;
    int n_errors;
    int cyc;
    logic exp_vld;
    logic [W-1:0] exp_q[$];

    ixc_gfifo_port_arb #(
        .NREQ(NREQ), .DW(DW), .CREDITS(CREDITS), .CW(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .gnt(gnt), .si_vld(si_vld), .si_data(si_data), .si_src(si_src), .si_last(si_last),
        .co_cred(co_cred), .cred_cnt(cred_cnt), .err_ovf(err_ovf),
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        req      = '0;
        req_last = '0;
        co_cred  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_vld = 1'b0;
        exp_q.delete();
        #1;
    endtask

    // One cycle: drive at negedge, check gnt and the output stage, then record the expected beat.
    task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                         input logic c, input logic [NREQ-1:0] exp_gnt);
        int idx;
        logic [W-1:0] e;
        @(negedge clk);
        cyc++;
        req      = r;
        req_last = l;
        co_cred  = c;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = 32'hC0DE_0000 | DW'(i << 8) | DW'(cyc & 8'hFF);
        end
        #1;
        check_eq("gnt", 64'(gnt), 64'(exp_gnt));
        check_eq("si_vld", 64'(si_vld), 64'(exp_vld));
        if (exp_vld && si_vld) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_empty", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("beat", 64'({si_src, si_last, si_data}), 64'(e));
            end
        end
        exp_vld = (exp_gnt != '0);
        if (exp_vld) begin
            idx = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (exp_gnt[i]) idx = i;
            end
            exp_q.push_back({3'(idx), l[idx], req_data[idx*DW +: DW]});
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        exp_vld  = 1'b0;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        req_last = '0;
        co_cred  = 1'b0;
        do_reset();

        // Reset state
        check_eq("rst_vld", 64'(si_vld), 64'(0));
        check_eq("rst_cred", 64'(cred_cnt), 64'(CREDITS));
        check_eq("rst_ovf", 64'(err_ovf), 64'(0));
        check_eq("rst_state", 64'(dbg_state), 64'(0));
        check_eq("rst_rr", 64'(dbg_rr_ptr), 64'(0));
        check_eq("rst_data", 64'({si_src, si_last, si_data}), 64'(0));

        // Overflow: return credit on a full counter
        cycle(4'h0, 4'h0, 1'b1, 4'h0);
        cycle(4'h0, 4'h0, 1'b0, 4'h0);
        check_eq("ovf_cred", 64'(cred_cnt), 64'(CREDITS));
        check_eq("ovf_set", 64'(err_ovf), 64'(1));
        for (int n = 0; n < 5; n++) cycle(4'h0, 4'h0, 1'b0, 4'h0);
        check_eq("ovf_sticky", 64'(err_ovf), 64'(1));
        do_reset();
        check_eq("ovf_clear", 64'(err_ovf), 64'(0));

        // Round robin, single-beat packets, credit returned one cycle behind si_vld
        for (int n = 0; n < 12; n++) begin
            cycle(4'hF, 4'hF, (n >= 2), 4'(1 << (n % 4)));
            check_eq("rr_cred", 64'(cred_cnt), 64'((n == 0) ? 8 : (n == 1) ? 7 : 6));
        end
        cycle(4'h0, 4'h0, 1'b1, 4'h0);
        do_reset();

        // Lock: requester 2 sends 3 beats with a bubble while 0 and 1 request
        cycle(4'h4, 4'h0, 1'b0, 4'h4);
        cycle(4'h3, 4'h0, 1'b0, 4'h0);
        check_eq("lock_state", 64'(dbg_state), 64'(1));
        cycle(4'h7, 4'h0, 1'b0, 4'h4);
        cycle(4'h7, 4'h7, 1'b0, 4'h4);
        cycle(4'h3, 4'h3, 1'b0, 4'h1);
        check_eq("unlock_state", 64'(dbg_state), 64'(0));
        check_eq("unlock_rr", 64'(dbg_rr_ptr), 64'(3));
        cycle(4'h0, 4'h0, 1'b0, 4'h0);
        check_eq("lock_rr_after", 64'(dbg_rr_ptr), 64'(1));
        do_reset();

        // Credit exhaustion: requester 1 streams with no returns
        for (int n = 0; n < 8; n++) begin
            cycle(4'h2, 4'h2, 1'b0, 4'h2);
            check_eq("exh_cred", 64'(cred_cnt), 64'(8 - n));
        end
        cycle(4'h2, 4'h2, 1'b0, 4'h0);
        check_eq("exh_zero", 64'(cred_cnt), 64'(0));
        cycle(4'h2, 4'h2, 1'b1, 4'h0);
        check_eq("exh_pulse", 64'(cred_cnt), 64'(0));
        cycle(4'h2, 4'h2, 1'b0, 4'h2);
        check_eq("exh_ret", 64'(cred_cnt), 64'(1));
        cycle(4'h2, 4'h2, 1'b1, 4'h0);
        check_eq("exh_zero2", 64'(cred_cnt), 64'(0));

        // Simultaneous consume and return with one credit
        for (int n = 0; n < 10; n++) begin
            cycle(4'h2, 4'h2, 1'b1, 4'h2);
            check_eq("sim_cred", 64'(cred_cnt), 64'(1));
        end
        cycle(4'h0, 4'h0, 1'b0, 4'h0);
        check_eq("sim_end", 64'(cred_cnt), 64'(1));
        do_reset();

        // Reset in the middle of a packet from requester 2
        cycle(4'h4, 4'h0, 1'b0, 4'h4);
        cycle(4'h4, 4'h0, 1'b0, 4'h4);
        check_eq("ml_state", 64'(dbg_state), 64'(1));
        check_eq("ml_cred", 64'(cred_cnt), 64'(7));
        do_reset();
        check_eq("mr_vld", 64'(si_vld), 64'(0));
        check_eq("mr_state", 64'(dbg_state), 64'(0));
        check_eq("mr_cred", 64'(cred_cnt), 64'(CREDITS));
        check_eq("mr_rr", 64'(dbg_rr_ptr), 64'(0));
        cycle(4'hF, 4'hF, 1'b0, 4'h1);
        cycle(4'h0, 4'h0, 1'b0, 4'h0);
        check_eq("mr_src", 64'(si_src), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
